// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite command sequencer.
//   PKG_DATA_WIDTH / PKG_ADDR_WIDTH : widths of the downstream axi4_lite_top
//   seq_state_e                     : issue FSM state encoding
//   cmd_t                           : one queued command {write, addr, wdata}
package axi4_lite_pkg;

   localparam int PKG_DATA_WIDTH = 32;
   localparam int PKG_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic                      write;
      logic [PKG_ADDR_WIDTH-1:0] addr;
      logic [PKG_DATA_WIDTH-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit read/write pointers.
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : write when push && !full
//   pop, dout    : dout is the head entry; pop advances when !empty
//   full, empty  : occupancy flags
//   count        : occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   // Same index with differing wrap bits means the write pointer is a full lap ahead.
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/axi4_lite_cmd_sequencer.sv
// Queues read/write commands and issues them one at a time to axi4_lite_top,
// spacing start pulses by a fixed cycle budget and capturing read data a fixed
// number of cycles after each read start.
//   ACLK, ARESET                  : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command input handshake
//   read_s, write_s, address, W_data : drive axi4_lite_top
//   R_data                        : read data from axi4_lite_top
//   rsp_valid, rsp_addr, rsp_data : one-cycle read response
//   busy, cmd_count               : activity and queue occupancy
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// ISSUE | start pulse high, command registers hold the popped head
// WAIT  | spacing counter running down before the next issue
module axi4_lite_cmd_sequencer
   import axi4_lite_pkg::*;
#(
   parameter int DATA_WIDTH = PKG_DATA_WIDTH,
   parameter int ADDRESS    = PKG_ADDR_WIDTH,
   parameter int DEPTH      = 4,
   parameter int SPACING    = 8,
   parameter int RD_CAPTURE = 6
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDRESS-1:0]      cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   output logic                    read_s,
   output logic                    write_s,
   output logic [ADDRESS-1:0]      address,
   output logic [DATA_WIDTH-1:0]   W_data,
   input  logic [DATA_WIDTH-1:0]   R_data,
   output logic                    rsp_valid,
   output logic [ADDRESS-1:0]      rsp_addr,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  cmd_count
);

   localparam int CW = $clog2(SPACING + 1);
   localparam logic [CW-1:0] SPACE_LOAD = CW'(SPACING - 2);
   localparam logic [CW-1:0] CAP_LOAD   = CW'(RD_CAPTURE - 1);

   cmd_t       fifo_din, fifo_dout;
   logic       fifo_full, fifo_empty, fifo_pop;

   seq_state_e                state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [CW-1:0]             cap_cnt_q, cap_cnt_d;
   logic                      cap_busy_q, cap_busy_d;
   logic                      read_s_q, read_s_d;
   logic                      write_s_q, write_s_d;
   logic [ADDRESS-1:0]        address_q, address_d;
   logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [ADDRESS-1:0]        rsp_addr_q, rsp_addr_d;
   logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic                      start;

   assign fifo_din = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

   sync_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (cmd_valid),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (cmd_count)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_cnt_d   = cap_cnt_q;
      cap_busy_d  = cap_busy_q;
      address_d   = address_q;
      w_data_d    = w_data_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_data_d  = rsp_data_q;
      read_s_d    = 1'b0;
      write_s_d   = 1'b0;
      rsp_valid_d = 1'b0;
      start       = 1'b0;

      case (state_q)
         IDLE:  if (!fifo_empty) start = 1'b1;
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = SPACE_LOAD;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               if (!fifo_empty) start = 1'b1;
               else             state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // address_q still holds the read's address here because the next issue
      // is at least SPACING cycles after the read start.
      if (cap_busy_q) begin
         if (cap_cnt_q == '0) begin
            cap_busy_d  = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = R_data;
            rsp_addr_d  = address_q;
         end else begin
            cap_cnt_d = cap_cnt_q - 1'b1;
         end
      end

      // The pop and the pulse are registered on the edge entering ISSUE, so
      // the pulse and its address are both visible during the ISSUE cycle.
      if (start) begin
         state_d   = ISSUE;
         address_d = fifo_dout.addr;
         if (fifo_dout.write) begin
            write_s_d = 1'b1;
            w_data_d  = fifo_dout.wdata;
         end else begin
            read_s_d   = 1'b1;
            cap_busy_d = 1'b1;
            cap_cnt_d  = CAP_LOAD;
         end
      end
   end

   assign fifo_pop = start;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cap_cnt_q   <= '0;
         cap_busy_q  <= 1'b0;
         read_s_q    <= 1'b0;
         write_s_q   <= 1'b0;
         address_q   <= '0;
         w_data_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         cap_busy_q  <= cap_busy_d;
         read_s_q    <= read_s_d;
         write_s_q   <= write_s_d;
         address_q   <= address_d;
         w_data_q    <= w_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign cmd_ready = !fifo_full;
   assign read_s    = read_s_q;
   assign write_s   = write_s_q;
   assign address   = address_q;
   assign W_data    = w_data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// Scoreboard bench for axi4_lite_cmd_sequencer. A small memory stands in for
// axi4_lite_top: writes land on write_s, R_data follows address.
module tb_axi4_lite_cmd_sequencer;

   localparam int SPACING    = 8;
   localparam int RD_CAPTURE = 6;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        read_s, write_s;
   logic [31:0] address, W_data, R_data;
   logic        rsp_valid;
   logic [31:0] rsp_addr, rsp_data;
   logic        busy;
   logic [2:0]  cmd_count;

   axi4_lite_cmd_sequencer #(
      .DATA_WIDTH (32), .ADDRESS (32), .DEPTH (4),
      .SPACING (SPACING), .RD_CAPTURE (RD_CAPTURE)
   ) dut (
      .ACLK (ACLK), .ARESET (ARESET),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
      .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
      .read_s (read_s), .write_s (write_s), .address (address), .W_data (W_data),
      .R_data (R_data),
      .rsp_valid (rsp_valid), .rsp_addr (rsp_addr), .rsp_data (rsp_data),
      .busy (busy), .cmd_count (cmd_count)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   typedef struct { logic w; logic [31:0] a; logic [31:0] d; } iss_t;
   typedef struct { logic [31:0] a; logic [31:0] d; } rsp_t;
   iss_t exp_iss[$];
   rsp_t exp_rsp[$];

   int vectors     = 0;
   int miscompares = 0;
   bit b2b         = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Slave stand-in
   logic [31:0] mem [logic [31:0]];
   initial begin
      R_data = '0;
      forever begin
         @(negedge ACLK);
         if (write_s && !ARESET) mem[address] = W_data;
         R_data = mem.exists(address) ? mem[address] : 32'h0;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a start or a response
   initial begin : monitor
      int   prev_pulse_cyc = -100;
      int   last_rd_cyc    = -100;
      bit   prev_b2b       = 1'b0;
      bit   prev_pulse     = 1'b0;
      logic [31:0] model_wdata = '0;
      iss_t e;
      rsp_t r;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            prev_pulse  = 1'b0;
            prev_b2b    = 1'b0;
            model_wdata = '0;
            continue;
         end
         if (read_s || write_s) begin
            chk("start_exclusive", {31'd0, read_s & write_s}, 32'd0);
            chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
            if (b2b && prev_b2b) chk("spacing", cyc - prev_pulse_cyc, SPACING);
            if (exp_iss.size() == 0) fail_now("unexpected_start");
            else begin
               e = exp_iss.pop_front();
               chk("start_kind", {31'd0, write_s}, {31'd0, e.w});
               chk("address", address, e.a);
               if (e.w) model_wdata = e.d;
               chk("W_data", W_data, model_wdata);
            end
            if (read_s) last_rd_cyc = cyc;
            prev_pulse_cyc = cyc;
            prev_b2b       = b2b;
         end
         prev_pulse = read_s || write_s;
         if (rsp_valid) begin
            if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
            else begin
               r = exp_rsp.pop_front();
               chk("rsp_addr", rsp_addr, r.a);
               chk("rsp_data", rsp_data, r.d);
               chk("rsp_latency", cyc - last_rd_cyc, RD_CAPTURE);
            end
         end
      end
   end

   // Called and returns at a falling edge; back-to-back calls keep cmd_valid high.
   task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd_exp);
      int n = 0;
      bit ok;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = w ? d : 32'hBAD0_0000;
      do begin
         ok = cmd_ready;
         @(posedge ACLK);
         n++;
         if (!ok) @(negedge ACLK);
      end while (!ok && n < 60);
      if (!ok) fail_now("push_timeout");
      else begin
         exp_iss.push_back('{w, a, d});
         if (!w) exp_rsp.push_back('{a, rd_exp});
      end
      @(negedge ACLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin
         @(negedge ACLK);
         n++;
      end
      if (busy) fail_now("idle_timeout");
      repeat (2) @(negedge ACLK);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_read_s"},    {31'd0, read_s},    32'd0);
      chk({tag, "_write_s"},   {31'd0, write_s},   32'd0);
      chk({tag, "_address"},   address,            32'd0);
      chk({tag, "_W_data"},    W_data,             32'd0);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_addr"},  rsp_addr,           32'd0);
      chk({tag, "_rsp_data"},  rsp_data,           32'd0);
      chk({tag, "_busy"},      {31'd0, busy},      32'd0);
      chk({tag, "_cmd_count"}, {29'd0, cmd_count}, 32'd0);
      chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin : main
      int n;
      ARESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check_quiet("reset");
      ARESET = 1'b0;
      repeat (3) @(negedge ACLK);
      check_quiet("idle");

      // Single write, then a read of the same address
      push_cmd(1'b1, 32'h04, 32'hDEAD_BEEF, 32'h0);
      chk("latency_before", {31'd0, write_s}, 32'd0);
      @(negedge ACLK);
      chk("latency_pulse", {31'd0, write_s}, 32'd1);
      wait_idle(40);

      push_cmd(1'b0, 32'h04, 32'h0, 32'hDEAD_BEEF);
      b2b = 1'b1;
      for (int i = 0; i < 4; i++)
         push_cmd(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 32'h0);
      chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("full_cmd_count", {29'd0, cmd_count}, 32'd4);

      // Hold a command while full; the pop edge must not accept it
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h10;
      cmd_wdata = 32'h5555_AAAA;
      n = 0;
      while (!(read_s || write_s) && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      if (!(read_s || write_s)) fail_now("pop_wait_timeout");
      chk("pop_cmd_count", {29'd0, cmd_count}, 32'd3);
      chk("pop_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      push_cmd(1'b1, 32'h10, 32'h5555_AAAA, 32'h0);
      wait_idle(100);
      b2b = 1'b0;

      // Alternating write/read to 0x08
      push_cmd(1'b1, 32'h08, 32'h1, 32'h0);
      push_cmd(1'b0, 32'h08, 32'h0, 32'h1);
      push_cmd(1'b1, 32'h08, 32'h2, 32'h0);
      push_cmd(1'b0, 32'h08, 32'h0, 32'h2);
      push_cmd(1'b1, 32'h08, 32'h3, 32'h0);
      push_cmd(1'b0, 32'h08, 32'h0, 32'h3);
      wait_idle(120);

      // Ten streamed commands: pointers wrap several times
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0)
            push_cmd(1'b1, 32'h40 + 32'(4 * (i / 2)), 32'hA000_0000 + 32'(i), 32'h0);
         else
            push_cmd(1'b0, 32'h40 + 32'(4 * (i / 2)), 32'h0, 32'hA000_0000 + 32'(i - 1));
         b2b = 1'b1;
      end
      wait_idle(200);
      b2b = 1'b0;
      chk("issue_queue_drained", exp_iss.size(), 32'd0);
      chk("rsp_queue_drained", exp_rsp.size(), 32'd0);

      // Reset during WAIT drops the queued command
      push_cmd(1'b1, 32'h20, 32'h1234_5678, 32'h0);
      push_cmd(1'b1, 32'h24, 32'h9ABC_DEF0, 32'h0);
      repeat (2) @(negedge ACLK);
      chk("mid_wait_busy", {31'd0, busy}, 32'd1);
      ARESET = 1'b1;
      exp_iss.delete();
      exp_rsp.delete();
      #1;
      check_quiet("midreset");
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      repeat (12) @(negedge ACLK);
      check_quiet("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout (t=%0t)", $time);
      $fatal(1, "bench did not complete");
   end

endmodule
